// File: rtl/flu_wb_arbiter_pkg.sv
// Shared types for the FLU writeback arbiter: exception record and buffered writeback entry.
package flu_wb_arbiter_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned FLU_LL_PORTS  = 2;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               ex;
    } flu_wb_entry_t;

endpackage

// File: rtl/flu_wb_fifo.sv
// Small result FIFO for one long-latency requester; DEPTH must be a power of two.
module flu_wb_fifo
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  flu_wb_entry_t i_data,
    input  logic          i_pop,
    output flu_wb_entry_t o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    flu_wb_entry_t  r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/flu_wb_arbiter.sv
// FLU writeback-port arbiter: single-cycle path has absolute priority, two buffered
// long-latency ports share the remainder round-robin. Optional starvation guard: FLU_ARB_STARVE_GUARD_EN.
module flu_wb_arbiter
    import flu_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic                                         flush_i,
    input  logic                                         sc_valid_i,
    input  logic [XLEN-1:0]                              sc_result_i,
    input  logic [TRANS_ID_BITS-1:0]                     sc_trans_id_i,
    input  exception_t                                   sc_exception_i,
    output logic                                         sc_stall_o,
    input  logic [FLU_LL_PORTS-1:0]                      ll_valid_i,
    output logic [FLU_LL_PORTS-1:0]                      ll_ready_o,
    input  logic [FLU_LL_PORTS-1:0][XLEN-1:0]            ll_result_i,
    input  logic [FLU_LL_PORTS-1:0][TRANS_ID_BITS-1:0]   ll_trans_id_i,
    input  exception_t [FLU_LL_PORTS-1:0]                ll_exception_i,
    output logic                                         wb_valid_o,
    output logic [XLEN-1:0]                              wb_result_o,
    output logic [TRANS_ID_BITS-1:0]                     wb_trans_id_o,
    output exception_t                                   wb_exception_o,
    output logic                                         ll_pending_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX < 2) begin : g_bad_param
        $error("flu_wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_MAX >= 2");
    end

    logic [FLU_LL_PORTS-1:0]          w_full;
    logic [FLU_LL_PORTS-1:0]          w_empty;
    logic [FLU_LL_PORTS-1:0]          w_push;
    logic [FLU_LL_PORTS-1:0]          w_pop;
    logic [FLU_LL_PORTS-1:0]          w_head_vld;
    flu_wb_entry_t [FLU_LL_PORTS-1:0] w_in;
    flu_wb_entry_t [FLU_LL_PORTS-1:0] w_head;
    logic                             w_contested;
    logic                             w_ll_grant;
    logic                             w_sel;
    logic                             r_rr;

    for (genvar p = 0; p < FLU_LL_PORTS; p++) begin : g_port
        assign ll_ready_o[p] = !w_full[p] && !flush_i;
        assign w_push[p]     = ll_valid_i[p] && ll_ready_o[p];
        assign w_head_vld[p] = !w_empty[p] && !flush_i;
        assign w_in[p]       = '{result: ll_result_i[p], trans_id: ll_trans_id_i[p], ex: ll_exception_i[p]};

        flu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_flush (flush_i),
            .i_push  (w_push[p]),
            .i_data  (w_in[p]),
            .i_pop   (w_pop[p]),
            .o_data  (w_head[p]),
            .o_full  (w_full[p]),
            .o_empty (w_empty[p])
        );
    end

    assign ll_pending_o = |(~w_empty);

    // Grant mux: single-cycle first, then the lone valid head, else the rr choice.
    always_comb begin
        w_contested    = &w_head_vld;
        w_ll_grant     = !sc_valid_i && (|w_head_vld);
        w_sel          = w_contested ? r_rr : w_head_vld[1];
        w_pop          = '0;
        wb_valid_o     = 1'b0;
        wb_result_o    = '0;
        wb_trans_id_o  = '0;
        wb_exception_o = '0;
        if (sc_valid_i) begin
            wb_valid_o     = 1'b1;
            wb_result_o    = sc_result_i;
            wb_trans_id_o  = sc_trans_id_i;
            wb_exception_o = sc_exception_i;
        end else if (w_ll_grant) begin
            w_pop[w_sel]   = 1'b1;
            wb_valid_o     = 1'b1;
            wb_result_o    = w_head[w_sel].result;
            wb_trans_id_o  = w_head[w_sel].trans_id;
            wb_exception_o = w_head[w_sel].ex;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= 1'b0;
        end else if (flush_i) begin
            r_rr <= 1'b0;
        end else if (w_ll_grant && w_contested) begin
            r_rr <= !r_rr;
        end
    end

`ifdef FLU_ARB_STARVE_GUARD_EN
    localparam int unsigned CNTW = $clog2(STARVE_MAX + 1);

    logic [CNTW-1:0] r_cnt;
    logic            r_stall;
    logic            w_starve_inc;
    logic            w_fire;

    assign w_starve_inc = sc_valid_i && ll_pending_o;
    assign w_fire       = w_starve_inc && (r_cnt == CNTW'(STARVE_MAX - 1));

    // The cycle that would make cnt reach STARVE_MAX arms a one-cycle stall instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else if (flush_i) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            r_stall <= w_fire;
            if (w_ll_grant || !ll_pending_o || w_fire) begin
                r_cnt <= '0;
            end else if (w_starve_inc && (r_cnt != CNTW'(STARVE_MAX))) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign sc_stall_o = r_stall;

    a_no_sc_during_stall: assert property (@(posedge clk_i) disable iff (!rst_ni) r_stall |-> !sc_valid_i);
`else
    assign sc_stall_o = 1'b0;
`endif

endmodule
